// File: rtl/pampy_pkg.sv
// Shared definitions for the pamPy stack core: op codes and error codes.
package pampy_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_BINOP = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_ROT2  = 3'd5;
  localparam logic [2:0] OP_ROT3  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;

endpackage

// File: rtl/pampy_stack_ram.sv
// Spill storage for the operand stack: synchronous write, asynchronous read, no reset.
module pampy_stack_ram #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Entries   = 13,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem_q [Entries];

  // Write port: one spill per cycle at most.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pampy_operand_stack.sv
// Operand stack: top three entries cached in registers, the rest spilled to a small RAM.
// One op per cycle with overflow/underflow detection, sticky error code and high-water mark.
module pampy_operand_stack
  import pampy_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  op_ready,
  output logic [DATA_WIDTH-1:0] tos_o,
  output logic [DATA_WIDTH-1:0] nos_o,
  output logic [DATA_WIDTH-1:0] third_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic [CNT_WIDTH-1:0]  hwm_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  localparam int RamEntries = DEPTH - 3;
  localparam int RamAw      = (RamEntries > 1) ? $clog2(RamEntries) : 1;

  localparam logic [CNT_WIDTH-1:0] CntDepth = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] Cnt1     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] Cnt2     = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] Cnt3     = CNT_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0] Cnt4     = CNT_WIDTH'(4);

  logic [DATA_WIDTH-1:0] tos_q, tos_d, nos_q, nos_d, third_q, third_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, hwm_q, hwm_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic                  legal;
  logic [1:0]            fault;
  logic                  ram_we;
  logic [RamAw-1:0]      ram_wr_addr, ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data, refill;

  // Spill slot for the current third entry is c-3; the entry that moves into third is at c-4.
  assign ram_wr_addr = RamAw'(cnt_q - Cnt3);
  assign ram_rd_addr = RamAw'(cnt_q - Cnt4);
  assign refill      = (cnt_q >= Cnt4) ? ram_rd_data : '0;

  pampy_stack_ram #(
    .DataWidth(DATA_WIDTH),
    .Entries  (RamEntries),
    .AddrWidth(RamAw)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (ram_we),
    .wr_addr_i(ram_wr_addr),
    .wr_data_i(third_q),
    .rd_addr_i(ram_rd_addr),
    .rd_data_o(ram_rd_data)
  );

  // Legality decode against the pre-op occupancy.
  always_comb begin
    legal = 1'b1;
    fault = ERR_NONE;
    unique case (op_code)
      OP_PUSH: begin
        if (cnt_q == CntDepth) begin
          legal = 1'b0;
          fault = ERR_OVF;
        end
      end
      OP_DUP: begin
        if (cnt_q < Cnt1) begin
          legal = 1'b0;
          fault = ERR_UNF;
        end else if (cnt_q == CntDepth) begin
          legal = 1'b0;
          fault = ERR_OVF;
        end
      end
      OP_POP: begin
        if (cnt_q < Cnt1) begin
          legal = 1'b0;
          fault = ERR_UNF;
        end
      end
      OP_BINOP, OP_ROT2: begin
        if (cnt_q < Cnt2) begin
          legal = 1'b0;
          fault = ERR_UNF;
        end
      end
      OP_ROT3: begin
        if (cnt_q < Cnt3) begin
          legal = 1'b0;
          fault = ERR_UNF;
        end
      end
      default: ;
    endcase
  end

  // Next-state for cache, counter, high-water mark and error latch.
  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    third_d = third_q;
    cnt_d   = cnt_q;
    hwm_d   = hwm_q;
    err_d   = err_q;
    code_d  = code_q;
    ram_we  = 1'b0;
    if (op_valid && !legal) begin
      err_d = 1'b1;
      // Only the first error is recorded.
      if (!err_q) begin
        code_d = fault;
      end
    end else if (op_valid) begin
      unique case (op_code)
        OP_PUSH, OP_DUP: begin
          tos_d   = (op_code == OP_DUP) ? tos_q : din;
          nos_d   = tos_q;
          third_d = nos_q;
          cnt_d   = cnt_q + Cnt1;
          ram_we  = (cnt_q >= Cnt3);
        end
        OP_POP: begin
          tos_d   = nos_q;
          nos_d   = third_q;
          third_d = refill;
          cnt_d   = cnt_q - Cnt1;
        end
        OP_BINOP: begin
          tos_d   = din;
          nos_d   = third_q;
          third_d = refill;
          cnt_d   = cnt_q - Cnt1;
        end
        OP_ROT2: begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
        OP_ROT3: begin
          tos_d   = nos_q;
          nos_d   = third_q;
          third_d = tos_q;
        end
        OP_CLEAR: begin
          tos_d   = '0;
          nos_d   = '0;
          third_d = '0;
          cnt_d   = '0;
          hwm_d   = '0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
        default: ;
      endcase
      if (cnt_d > hwm_d) begin
        hwm_d = cnt_d;
      end
    end
  end

  // State registers; reset overrides any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos_q   <= '0;
      nos_q   <= '0;
      third_q <= '0;
      cnt_q   <= '0;
      hwm_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      third_q <= third_d;
      cnt_q   <= cnt_d;
      hwm_q   <= hwm_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign op_ready   = reset;
  assign tos_o      = tos_q;
  assign nos_o      = nos_q;
  assign third_o    = third_q;
  assign count_o    = cnt_q;
  assign hwm_o      = hwm_q;
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CntDepth);
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_pampy_operand_stack.sv
// Bench for pampy_operand_stack: queue-based reference stack, expected snapshots queued per op.
module tb_pampy_operand_stack;
  import pampy_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic [2:0]    op_code = OP_NOP;
  logic [DW-1:0] din = '0;
  logic          op_ready;
  logic [DW-1:0] tos_o, nos_o, third_o;
  logic [CW-1:0] count_o, hwm_o;
  logic          empty_o, full_o, err_o;
  logic [1:0]    err_code_o;

  typedef struct packed {
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [DW-1:0] third;
    logic [CW-1:0] count;
    logic [CW-1:0] hwm;
    logic          empty;
    logic          full;
    logic          err;
    logic [1:0]    code;
  } snap_t;

  snap_t         sb_q[$];
  logic [DW-1:0] m_stack[$];
  int            m_hwm = 0;
  logic          m_err = 1'b0;
  logic [1:0]    m_code = ERR_NONE;
  int            tests_run = 0;
  int            tests_failed = 0;

  always #5 clk = ~clk;

  pampy_operand_stack #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .din       (din),
    .op_ready  (op_ready),
    .tos_o     (tos_o),
    .nos_o     (nos_o),
    .third_o   (third_o),
    .count_o   (count_o),
    .hwm_o     (hwm_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .err_o     (err_o),
    .err_code_o(err_code_o)
  );

  function automatic snap_t observed();
    return {tos_o, nos_o, third_o, count_o, hwm_o, empty_o, full_o, err_o, err_code_o};
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    int c = m_stack.size();
    s.tos   = (c > 0) ? m_stack[0] : '0;
    s.nos   = (c > 1) ? m_stack[1] : '0;
    s.third = (c > 2) ? m_stack[2] : '0;
    s.count = CW'(c);
    s.hwm   = CW'(m_hwm);
    s.empty = (c == 0);
    s.full  = (c == DEPTH);
    s.err   = m_err;
    s.code  = m_code;
    return s;
  endfunction

  function automatic void model_fault(input logic [1:0] f);
    if (!m_err) m_code = f;
    m_err = 1'b1;
  endfunction

  function automatic void model_reset();
    m_stack.delete();
    m_hwm  = 0;
    m_err  = 1'b0;
    m_code = ERR_NONE;
  endfunction

  function automatic void model_apply(input logic [2:0] op, input logic [DW-1:0] d);
    int c = m_stack.size();
    logic [DW-1:0] t;
    case (op)
      OP_PUSH:  if (c < DEPTH) m_stack.push_front(d); else model_fault(ERR_OVF);
      OP_DUP: begin
        if (c == 0) model_fault(ERR_UNF);
        else if (c >= DEPTH) model_fault(ERR_OVF);
        else begin
          t = m_stack[0];
          m_stack.push_front(t);
        end
      end
      OP_POP:   if (c >= 1) void'(m_stack.pop_front()); else model_fault(ERR_UNF);
      OP_BINOP: begin
        if (c >= 2) begin
          void'(m_stack.pop_front());
          void'(m_stack.pop_front());
          m_stack.push_front(d);
        end else model_fault(ERR_UNF);
      end
      OP_ROT2: begin
        if (c >= 2) begin
          t = m_stack[0]; m_stack[0] = m_stack[1]; m_stack[1] = t;
        end else model_fault(ERR_UNF);
      end
      OP_ROT3: begin
        if (c >= 3) begin
          t = m_stack[0]; m_stack[0] = m_stack[1]; m_stack[1] = m_stack[2]; m_stack[2] = t;
        end else model_fault(ERR_UNF);
      end
      OP_CLEAR: model_reset();
      default: ;
    endcase
    if (m_stack.size() > m_hwm) m_hwm = m_stack.size();
  endfunction

  // Drive one op, queue the expected snapshot, and return #1 after the capturing edge.
  task automatic issue(input logic v, input logic [2:0] op, input logic [DW-1:0] d);
    op_valid = v;
    op_code  = op;
    din      = d;
    if (v) model_apply(op, d);
    sb_q.push_back(model_snap());
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = OP_NOP;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    tests_run++;
    if (observed() !== snap_t'({8'h0, 8'h0, 8'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0})
        || op_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h ready=%b, want all zero empty=1 ready=0",
               observed(), op_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (op_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset: got %b want 1", op_ready);
    end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    snap_t exp, got;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) issue(1'b1, OP_PUSH, vals[i]);
      else issue(1'b1, OP_POP, 8'h00);
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL push_pop step %0d: got %h want %h", i, got, exp);
      end
      if (i == 3) begin
        tests_run++;
        if (tos_o !== 8'h44 || nos_o !== 8'h33 || third_o !== 8'h22 || count_o !== 5'd4
            || hwm_o !== 5'd4) begin
          tests_failed++;
          $display("FAIL push4_values: got tos=%h nos=%h third=%h count=%0d hwm=%0d, want 44 33 22 4 4",
                   tos_o, nos_o, third_o, count_o, hwm_o);
        end
      end
    end
    tests_run++;
    if (tos_o !== 8'h11 || count_o !== 5'd1 || nos_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL pop3_values: got tos=%h nos=%h count=%0d, want 11 00 1", tos_o, nos_o, count_o);
    end
  endtask

  task automatic test_overflow();
    snap_t exp, got;
    issue(1'b1, OP_CLEAR, 8'h00);
    void'(sb_q.pop_front());
    for (int i = 0; i < DEPTH + 1; i++) begin
      issue(1'b1, OP_PUSH, DW'(8'hA0 + i));
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL overflow step %0d: got %h want %h", i, got, exp);
      end
      if (i == DEPTH - 1) begin
        tests_run++;
        if (full_o !== 1'b1 || err_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_flag: got full=%b err=%b want 1 0", full_o, err_o);
        end
      end
    end
    tests_run++;
    if (err_o !== 1'b1 || err_code_o !== ERR_OVF || count_o !== 5'd16 || tos_o !== 8'hAF) begin
      tests_failed++;
      $display("FAIL overflow_err: got err=%b code=%0d count=%0d tos=%h want 1 1 16 af",
               err_o, err_code_o, count_o, tos_o);
    end
    // Drain through the spill array back to empty.
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, OP_POP, 8'h00);
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL drain step %0d: got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_underflow();
    snap_t exp, got;
    logic [2:0]    ops[4] = '{OP_CLEAR, OP_POP, OP_PUSH, OP_CLEAR};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, ops[i], 8'h05);
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL underflow step %0d: got %h want %h", i, got, exp);
      end
      if (i == 2) begin
        tests_run++;
        if (tos_o !== 8'h05 || count_o !== 5'd1 || err_o !== 1'b1 || err_code_o !== ERR_UNF) begin
          tests_failed++;
          $display("FAIL unf_sticky: got tos=%h count=%0d err=%b code=%0d want 05 1 1 2",
                   tos_o, count_o, err_o, err_code_o);
        end
      end
    end
    tests_run++;
    if (err_o !== 1'b0 || err_code_o !== ERR_NONE || count_o !== 5'd0 || hwm_o !== 5'd0) begin
      tests_failed++;
      $display("FAIL clear_err: got err=%b code=%0d count=%0d hwm=%0d want 0 0 0 0",
               err_o, err_code_o, count_o, hwm_o);
    end
  endtask

  task automatic test_binop_rot();
    snap_t exp, got;
    logic [2:0]    ops[7] = '{OP_CLEAR, OP_PUSH, OP_PUSH, OP_PUSH, OP_PUSH, OP_BINOP, OP_ROT3};
    logic [DW-1:0] ds[7]  = '{8'h00, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0B, 8'h00};
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, ops[i], ds[i]);
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL binop_rot step %0d: got %h want %h", i, got, exp);
      end
      if (i == 5) begin
        tests_run++;
        if (tos_o !== 8'h0B || nos_o !== 8'h04 || third_o !== 8'h03 || count_o !== 5'd3) begin
          tests_failed++;
          $display("FAIL binop_values: got %h %h %h count=%0d want 0b 04 03 3",
                   tos_o, nos_o, third_o, count_o);
        end
      end
    end
    tests_run++;
    if (tos_o !== 8'h04 || nos_o !== 8'h03 || third_o !== 8'h0B || hwm_o !== 5'd4) begin
      tests_failed++;
      $display("FAIL rot3_values: got %h %h %h hwm=%0d want 04 03 0b 4",
               tos_o, nos_o, third_o, hwm_o);
    end
  endtask

  task automatic test_dup_rot2();
    snap_t exp, got;
    logic [2:0]    ops[5] = '{OP_CLEAR, OP_PUSH, OP_DUP, OP_ROT2, OP_ROT3};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, ops[i], 8'h07);
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL dup_rot2 step %0d: got %h want %h", i, got, exp);
      end
    end
    tests_run++;
    if (tos_o !== 8'h07 || nos_o !== 8'h07 || count_o !== 5'd2 || err_o !== 1'b1
        || err_code_o !== ERR_UNF) begin
      tests_failed++;
      $display("FAIL rot3_illegal: got tos=%h nos=%h count=%0d err=%b code=%0d want 07 07 2 1 2",
               tos_o, nos_o, count_o, err_o, err_code_o);
    end
  endtask

  task automatic test_reset_mid();
    snap_t exp, got;
    issue(1'b1, OP_CLEAR, 8'h00);
    void'(sb_q.pop_front());
    for (int i = 0; i < 9; i++) begin
      issue(1'b1, OP_PUSH, DW'(8'h30 + i));
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL burst step %0d: got %h want %h", i, got, exp);
      end
    end
    op_valid = 1'b1;
    op_code  = OP_PUSH;
    din      = 8'hAA;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (observed() !== snap_t'({8'h0, 8'h0, 8'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0})
        || op_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got %h ready=%b want all zero empty=1 ready=0",
               observed(), op_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (count_o !== 5'd0 || tos_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_overrides_op: got count=%0d tos=%h want 0 00", count_o, tos_o);
    end
    op_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    issue(1'b1, OP_PUSH, 8'h5A);
    got = observed(); exp = sb_q.pop_front(); tests_run++;
    if (got !== exp || tos_o !== 8'h5A || count_o !== 5'd1) begin
      tests_failed++;
      $display("FAIL first_after_reset: got %h want %h (tos 5a count 1)", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    snap_t exp, got;
    int r;
    logic [2:0] op;
    logic v;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      v = 1'b1;
      if (r < 35) op = OP_PUSH;
      else if (r < 55) op = OP_POP;
      else if (r < 65) op = OP_BINOP;
      else if (r < 72) op = OP_DUP;
      else if (r < 79) op = OP_ROT2;
      else if (r < 86) op = OP_ROT3;
      else if (r < 90) op = OP_NOP;
      else if (r < 93) op = OP_CLEAR;
      else begin
        op = OP_POP;
        v  = 1'b0;
      end
      issue(v, op, DW'($urandom_range(0, 255)));
      got = observed(); exp = sb_q.pop_front(); tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random step %0d op=%0d v=%b: got %h want %h", i, op, v, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_binop_rot();
    test_dup_rot2();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
